// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Frame start marker; everything before it is discarded
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Word count carried in the frame header
  typedef logic [15:0] len_t;

  // Byte address of word idx relative to the image base
  function automatic logic [31:0] word_addr(input logic [31:0] base, input len_t idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  // Host side: drives the byte stream and observes the memory writes
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words and emits a
// registered one-cycle valid pulse together with each completed word.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        lane_last_o,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] buf_q, buf_d;
  logic [31:0] word_q, word_d;
  logic        vld_q, vld_d;

  // Lane placement: lanes 0..2 are buffered, lane 3 completes the word
  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (byte_vld_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0: buf_d[7:0]   = byte_i;
        2'd1: buf_d[15:8]  = byte_i;
        2'd2: buf_d[23:16] = byte_i;
        default: begin
          word_d = {byte_i, buf_q};
          vld_d  = 1'b1;
        end
      endcase
    end
  end

  // Assembler registers; async reset also kills a pending write pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= 2'd0;
      buf_q  <= 24'd0;
      word_q <= 32'd0;
      vld_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign lane_last_o = (lane_q == 2'd3);
  assign word_vld_o  = vld_q;
  assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream (SYNC, LEN, data, CHK), writes
// the words into instruction memory and releases the core from reset only
// after the whole image has been written and its XOR checksum verified.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  state_e      state_q, state_d;
  len_t        len_q, len_d;
  len_t        idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] addr_q, addr_d;
  logic        in_ready_q, in_ready_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        core_reset_q, core_reset_d;

  logic        acc;
  logic        data_byte;
  logic        lane_last;
  logic        word_vld;
  logic [31:0] word;
  len_t        len_full;

  assign acc       = bus.in_valid && in_ready_q;
  assign data_byte = acc && (state_q == ST_DATA);
  // Full word count as it would be once LEN_HI is latched
  assign len_full  = {bus.in_data, len_q[7:0]};

  word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .byte_vld_i  (data_byte),
    .byte_i      (bus.in_data),
    .lane_last_o (lane_last),
    .word_vld_o  (word_vld),
    .word_o      (word)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE and ERROR are terminal until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:   if (acc && bus.in_data == SYNC_BYTE) state_d = ST_LEN_LO;
      ST_LEN_LO: if (acc) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (acc) begin
          if ({1'b0, len_full} > 17'(MEM_WORDS)) state_d = ST_ERROR;
          else if (len_full == 16'd0)            state_d = ST_CHECK;
          else                                   state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (acc && lane_last && idx_q == 16'(len_q - 16'd1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (acc) state_d = (bus.in_data == xor_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_SYNC;
    endcase
  end

  // Output decode from the next state so that status outputs are registered
  always_comb begin
    in_ready_d   = 1'b1;
    done_d       = 1'b0;
    error_d      = 1'b0;
    core_reset_d = 1'b1;
    case (state_d)
      ST_DONE: begin
        in_ready_d   = 1'b0;
        done_d       = 1'b1;
        core_reset_d = 1'b0;
      end
      ST_ERROR: begin
        in_ready_d = 1'b0;
        error_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Status output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Length capture, word index / address counter and checksum accumulator
  always_comb begin
    len_d  = len_q;
    idx_d  = idx_q;
    xor_d  = xor_q;
    addr_d = addr_q;
    if (acc) begin
      case (state_q)
        ST_LEN_LO: begin
          len_d = {8'h00, bus.in_data};
          xor_d = xor_q ^ bus.in_data;
        end
        ST_LEN_HI: begin
          len_d = len_full;
          xor_d = xor_q ^ bus.in_data;
        end
        ST_DATA: begin
          xor_d = xor_q ^ bus.in_data;
          if (lane_last) begin
            // Address lines up with the word leaving the assembler next cycle
            addr_d = word_addr(BASE_ADDR, idx_q);
            idx_d  = idx_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= 16'd0;
      idx_q  <= 16'd0;
      xor_q  <= 8'd0;
      addr_q <= BASE_ADDR;
    end else begin
      len_q  <= len_d;
      idx_q  <= idx_d;
      xor_q  <= xor_d;
      addr_q <= addr_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = word_vld;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame parsing, write timing, checksum,
// length limits, handshake gaps and asynchronous reset.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic core_reset, done, error;

  imem_loader_if bus ();

  imem_loader #(
    .MEM_WORDS (256),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Write log sampled on the falling edge
  int          wr_cnt = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1 && wr_cnt < 64) begin
      wr_addr[wr_cnt] <= bus.imem_addr;
      wr_data[wr_cnt] <= bus.imem_wdata;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  logic [7:0] t2 [14];
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic dn,
                            input logic er, input logic cr);
    chk({tag, ".in_ready"},   32'(bus.in_ready), 32'(rdy));
    chk({tag, ".done"},       32'(done),         32'(dn));
    chk({tag, ".error"},      32'(error),        32'(er));
    chk({tag, ".core_reset"}, 32'(core_reset),   32'(cr));
  endtask

  // One byte presented for exactly one rising edge
  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] last, input bit gaps);
    for (int i = 0; i < 14; i++) begin
      send((i == 13) ? last : t2[i]);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  task automatic chk_t2_writes(input string tag);
    chk({tag, ".wcount"}, 32'(wr_cnt - base), 32'd2);
    chk({tag, ".addr0"},  wr_addr[base],      32'h0000_0000);
    chk({tag, ".data0"},  wr_data[base],      32'h1011_1213);
    chk({tag, ".addr1"},  wr_addr[base+1],    32'h0000_0004);
    chk({tag, ".data1"},  wr_data[base+1],    32'h0A0B_0C0D);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t2 = '{8'h00, 8'h11, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h12,
           8'h11, 8'h10, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h02};
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Values while reset is held, then held idle after release
    repeat (3) @(negedge clk);
    chk_status("rst", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst.we",    32'(bus.imem_we), 32'd0);
    chk("rst.addr",  bus.imem_addr,    32'h0000_0000);
    chk("rst.wdata", bus.imem_wdata,   32'h0000_0000);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk_status("idle", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("idle.we", 32'(bus.imem_we), 32'd0);

    // Two-word image at full rate, write timing checked inline
    base = wr_cnt;
    for (int i = 0; i < 9; i++) send(t2[i]);
    @(negedge clk);
    chk("t2.we0",   32'(bus.imem_we), 32'd1);
    chk("t2.addr0", bus.imem_addr,    32'h0000_0000);
    chk("t2.wd0",   bus.imem_wdata,   32'h1011_1213);
    for (int i = 9; i < 13; i++) send(t2[i]);
    @(negedge clk);
    chk("t2.we1",   32'(bus.imem_we), 32'd1);
    chk("t2.addr1", bus.imem_addr,    32'h0000_0004);
    chk("t2.wd1",   bus.imem_wdata,   32'h0A0B_0C0D);
    chk_status("t2.pre", 1'b1, 1'b0, 1'b0, 1'b1);
    send(t2[13]);
    @(negedge clk);
    chk_status("t2.end", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2.we_end", 32'(bus.imem_we), 32'd0);
    idle(3);
    chk_t2_writes("t2");

    // Bad checksum: writes still happen, then error
    do_reset();
    base = wr_cnt;
    send_frame(8'h03, 1'b0);
    @(negedge clk);
    chk_status("t3", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk_t2_writes("t3");

    // Empty image
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h00);
    @(negedge clk);
    chk_status("t4.pre", 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h00);
    @(negedge clk);
    chk_status("t4", 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("t4.wcount", 32'(wr_cnt - base), 32'd0);

    // N = 257 exceeds capacity: error right after LEN_HI
    do_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h01);
    @(negedge clk);
    chk("t5.err_before", 32'(error), 32'd0);
    send(8'h01);
    @(negedge clk);
    chk_status("t5", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(3);
    chk("t5.wcount", 32'(wr_cnt - base), 32'd0);
    chk_status("t5.hold", 1'b0, 1'b0, 1'b1, 1'b1);

    // N = 256 is the largest legal length
    do_reset();
    send(8'hA5); send(8'h00); send(8'h01);
    @(negedge clk);
    chk_status("n256", 1'b1, 1'b0, 1'b0, 1'b1);

    // Same image with idle gaps between bytes
    do_reset();
    base = wr_cnt;
    send_frame(8'h02, 1'b1);
    @(negedge clk);
    chk_status("t6", 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk_t2_writes("t6");

    // Reset after the 7th byte, then full replay
    do_reset();
    for (int i = 0; i < 7; i++) send(t2[i]);
    reset = 1'b0;
    #1;
    chk_status("t7.rst", 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = wr_cnt;
    send_frame(8'h02, 1'b0);
    @(negedge clk);
    chk_status("t7", 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk_t2_writes("t7");

    // Reset arriving while a write pulse is high suppresses it at once
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 9; i++) send(t2[i]);
    chk("t8.we_live", 32'(bus.imem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("t8.we_killed", 32'(bus.imem_we), 32'd0);
    chk("t8.wdata",     bus.imem_wdata,   32'h0000_0000);
    chk("t8.addr",      bus.imem_addr,    32'h0000_0000);
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    chk("t8.wcount", 32'(wr_cnt - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory which the single-cycle core only reads. It receives a framed byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words, and issues one-cycle writes to the instruction-memory write port. It holds the core in reset until a complete, checksum-verified image has been written.

## Interface
- MEM_WORDS, 256: instruction-memory capacity in 32-bit words; the largest legal image length.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; the core's PC reset value.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the write, word-aligned.
- imem_wdata  out  32  word to write.
- core_reset  out  1  active-high reset to the core; 1 until load succeeds.
- done  out  1  image loaded and verified; sticky.
- error  out  1  framing, length or checksum failure; sticky.

## Operation
- Frame layout: SYNC byte 0xA5, LEN_LO, LEN_HI (16-bit word count N), 4·N data bytes (little-endian per word), CHK byte.
- Checksum: XOR of LEN_LO, LEN_HI and all data bytes. SYNC is excluded. Pass when the XOR equals CHK.
- States:
  - SYNC: accept and discard bytes until 0xA5 arrives, then go to LEN_LO.
  - LEN_LO: store the byte as the low half of N, then go to LEN_HI.
  - LEN_HI: store the byte as the high half of N.
    - If N > MEM_WORDS, go to ERROR.
    - Else if N == 0, go to CHECK.
    - Else go to DATA.
  - DATA: the byte lane counter (0..3) places byte k into bits [8k+7:8k].
    - On acceptance of lane 3, the assembled word is written.
    - The word index increments; after word N-1, go to CHECK.
  - CHECK: accept one byte and compare it with the running XOR. Match goes to DONE, otherwise ERROR.
  - DONE: in_ready=0, done=1, core_reset=0. The state is held until reset.
  - ERROR: in_ready=0, error=1, core_reset=1. The state is held until reset.
- in_ready = 1 in SYNC, LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERROR.
- Write address: imem_addr = BASE_ADDR + 4·index, where index is the 0-based word count. It uses 32-bit arithmetic with no wrap check beyond the N ≤ MEM_WORDS limit.
- The loader never reads memory. Partially written contents are left as-is on error or reset.

## Timing
- Reset values:
  - State = SYNC, in_ready = 1, imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - core_reset = 1, done = 0, error = 0.
  - Lane counter, word index, N and the XOR accumulator = 0.
- All outputs are registered.
- Write latency: imem_we is high exactly one cycle, in the cycle after lane 3 is accepted. imem_addr and imem_wdata are valid in that same cycle.
- Full rate: one byte per cycle is sustained. A write pulse for word n may coincide with acceptance of word n+1 lane 0, or of the CHK byte.
- in_valid gaps: state and counters hold, and no spurious write occurs.
- DONE/ERROR outputs (done, error, core_reset, in_ready) change in the cycle after the CHK byte is accepted. For ERROR by length, they change in the cycle after LEN_HI is accepted.
- The last imem_we always precedes the cycle where core_reset falls.
- Reset asserted mid-frame: all registers return to reset values asynchronously. Any write pulse in flight is suppressed from that point.

## Structure
- Shared package loader_pkg holds:
  - the state enum (SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - the SYNC_BYTE = 8'hA5 constant;
  - the 16-bit length type.
- One sub-module, word_assembler: lane counter, byte placement and the one-cycle word-valid pulse.
- The FSM, index/address counter and XOR accumulator stay in imem_loader.

## Test plan
- Reset released with in_valid=0 → core_reset=1, in_ready=1, imem_we=0, done=0, error=0 held indefinitely.
- Bytes 00,11,A5,02,00,13,12,11,10,0D,0C,0B,0A,02 (one per cycle) → expected response:
  - writes 0x10111213 @0x0 and 0x0A0B0C0D @0x4, each a one-cycle imem_we;
  - then done=1, core_reset=0, in_ready=0.
- Same stream with final byte 03 → both writes occur; error=1, done=0, core_reset=1, in_ready=0.
- A5,00,00,00 → no imem_we; done=1, core_reset=0.
- A5,01,01 (N=257 > MEM_WORDS) → error=1 the cycle after the third byte; no imem_we ever.
- Test 2 stream with in_valid deasserted randomly between bytes → identical writes and done. In a separate run, reset is asserted after the 7th byte and then test 2 is replayed → result identical to test 2.
